univ_shift_reg: RTL and testbench

Parametrised universal register, the successor to the plain parallel-load register. Adds multi-step shift and rotate operations in either direction, with a serial input and a serial output. Multi-step operations are sequenced by an internal counter, with a busy/done handshake. Used wherever datapath blocks need a loadable register that can also serialise, deserialise or rotate words.

---
 rtl/univ_shift_reg.sv | 84 ++++++++
 tb/tb_univ_shift_reg.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal register: parallel load plus counter-sequenced multi-step shift/rotate
// in either direction, with serial in/out and a busy/done handshake.
module univ_shift_reg #(
   parameter int width = 8,
   parameter int cnt_w = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [width-1:0] data_in,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [cnt_w-1:0] shamt,
   input  logic             ser_in,
   output logic [width-1:0] data_out,
   output logic             ser_out,
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE, SHIFT} state_t;

   localparam logic [1:0] SHL = 2'b00;
   localparam logic [1:0] SHR = 2'b01;
   localparam logic [1:0] ROL = 2'b10;

   state_t           state;
   logic [cnt_w-1:0] count;
   logic [1:0]       mode_q;

   // One single-bit step; the MSB of the result is the bit that leaves the word.
   function automatic logic [width:0] step(input logic [1:0] op,
                                           input logic [width-1:0] d,
                                           input logic fill);
      case (op)
         SHL:     step = {d[width-1], d[width-2:0], fill};
         SHR:     step = {d[0], fill, d[width-1:1]};
         ROL:     step = {d[width-1], d[width-2:0], d[width-1]};
         default: step = {d[0], d[0], d[width-1:1]};
      endcase
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         count    <= '0;
         mode_q   <= SHL;
         data_out <= '0;
         ser_out  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // Load has priority; a start in the same cycle is dropped.
               if (load) begin
                  data_out <= data_in;
               end else if (start) begin
                  if (shamt == '0) begin
                     done <= 1'b1;
                  end else begin
                     mode_q <= mode;
                     count  <= shamt;
                     busy   <= 1'b1;
                     state  <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               {ser_out, data_out} <= step(mode_q, data_out, ser_in);
               count <= count - cnt_w'(1);
               if (count == cnt_w'(1)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: a table of load/operate vectors with a
// result scoreboard, plus hand sequences for reset, abort, priority and ignore rules.
module tb_univ_shift_reg;

   logic       clk = 1'b0;
   logic       reset;
   logic       load;
   logic [7:0] data_in;
   logic       start;
   logic [1:0] mode;
   logic [3:0] shamt;
   logic       ser_in;
   logic [7:0] data_out;
   logic       ser_out;
   logic       busy;
   logic       done;

   univ_shift_reg #(.width(8), .cnt_w(4)) dut (
      .clk(clk), .reset(reset), .load(load), .data_in(data_in),
      .start(start), .mode(mode), .shamt(shamt), .ser_in(ser_in),
      .data_out(data_out), .ser_out(ser_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] ld;
      logic [1:0] md;
      logic [3:0] sh;
      logic       si;
      logic [7:0] ed;
      logic       es;
   } vec_t;

   typedef struct {
      logic [7:0] d;
      logic       s;
   } res_t;

   vec_t vecs[10];
   res_t sb[$];
   int   pass_cnt = 0;
   int   total_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Optionally load, launch one operation, then wait (bounded) for done and
   // compare against the scoreboard. With poke set, load/start are pulsed
   // during the first busy cycle and must be ignored.
   task automatic run_op(input bit do_load, input vec_t v, input bit poke);
      res_t r;
      int   cyc;
      int   busy_cnt;
      if (do_load) begin
         load = 1'b1; data_in = v.ld;
         tick();
         load = 1'b0;
         check("load_data", data_out, v.ld);
      end
      start = 1'b1; mode = v.md; shamt = v.sh; ser_in = v.si;
      sb.push_back('{d: v.ed, s: v.es});
      tick();
      start = 1'b0;
      mode  = ~v.md;
      shamt = 4'($urandom_range(0, 15));
      if (v.sh != 0) check("done_low_after_start", done, 1'b0);
      cyc = 0; busy_cnt = 0;
      while (!done && cyc < 40) begin
         if (busy) busy_cnt++;
         if (poke && cyc == 0) begin
            load = 1'b1; start = 1'b1; data_in = 8'hFF;
         end else if (poke && cyc == 1) begin
            load = 1'b0; start = 1'b0;
         end
         tick();
         cyc++;
      end
      load = 1'b0; start = 1'b0;
      if (!done) begin
         check("done_timeout", 1'b0, 1'b1);
         sb.delete();
      end else begin
         r = sb.pop_front();
         check("result_data", data_out, r.d);
         check("result_ser", ser_out, r.s);
         check("busy_cycles", busy_cnt, v.sh);
         check("busy_low_at_done", busy, 1'b0);
      end
   endtask

   initial begin
      int done_seen;
      // ld, mode, shamt, ser_in, expected data, expected ser_out
      vecs[0] = '{8'hAA, 2'b10, 4'd1,  1'b0, 8'h55, 1'b1};
      vecs[1] = '{8'h77, 2'b00, 4'd0,  1'b0, 8'h77, 1'b1};
      vecs[2] = '{8'h81, 2'b01, 4'd3,  1'b1, 8'hF0, 1'b0};
      vecs[3] = '{8'hA5, 2'b11, 4'd8,  1'b0, 8'hA5, 1'b1};
      vecs[4] = '{8'h0F, 2'b00, 4'd4,  1'b1, 8'hFF, 1'b0};
      vecs[5] = '{8'h3C, 2'b10, 4'd2,  1'b1, 8'hF0, 1'b0};
      vecs[6] = '{8'h96, 2'b00, 4'd10, 1'b1, 8'hFF, 1'b1};
      vecs[7] = '{8'hC3, 2'b01, 4'd1,  1'b0, 8'h61, 1'b1};
      vecs[8] = '{8'h01, 2'b11, 4'd1,  1'b1, 8'h80, 1'b1};
      vecs[9] = '{8'h80, 2'b10, 4'd3,  1'b0, 8'h04, 1'b0};

      reset = 1'b1; load = 1'b1; data_in = 8'hFF; start = 1'b0;
      mode = 2'b00; shamt = 4'd0; ser_in = 1'b0;
      repeat (3) tick();
      check("reset_data", data_out, 8'h00);
      check("reset_ser", ser_out, 1'b0);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      reset = 1'b0; load = 1'b0;
      tick();

      load = 1'b1; data_in = 8'hAA;
      tick();
      load = 1'b0;
      check("load_aa", data_out, 8'hAA);
      check("load_busy", busy, 1'b0);
      check("load_done", done, 1'b0);

      for (int i = 0; i < 10; i++) run_op(1'b1, vecs[i], 1'b0);

      // start accepted in the very cycle done is high: 04 rotr 3 -> 80
      run_op(1'b0, '{8'h00, 2'b11, 4'd3, 1'b0, 8'h80, 1'b1}, 1'b0);

      // load/start during busy ignored: 5A rotl 4 -> A5
      tick();
      run_op(1'b1, '{8'h5A, 2'b10, 4'd4, 1'b0, 8'hA5, 1'b1}, 1'b1);

      // serial-out sequence of 81 >> 3 with fill 1
      tick();
      load = 1'b1; data_in = 8'h81;
      tick();
      load = 1'b0; start = 1'b1; mode = 2'b01; shamt = 4'd3; ser_in = 1'b1;
      tick();
      start = 1'b0;
      check("shr_busy0", busy, 1'b1);
      tick();
      check("shr_ser1", ser_out, 1'b1);
      check("shr_data1", data_out, 8'hC0);
      tick();
      check("shr_ser2", ser_out, 1'b0);
      tick();
      check("shr_ser3", ser_out, 1'b0);
      check("shr_final", data_out, 8'hF0);
      check("shr_done", done, 1'b1);
      tick();
      check("shr_done_once", done, 1'b0);

      // load and start together: load wins
      load = 1'b1; start = 1'b1; data_in = 8'h3C; mode = 2'b10; shamt = 4'd3;
      tick();
      load = 1'b0; start = 1'b0;
      check("prio_data", data_out, 8'h3C);
      check("prio_busy", busy, 1'b0);
      tick();
      check("prio_busy2", busy, 1'b0);
      check("prio_done", done, 1'b0);

      // abort by reset after two steps of 0F << 5
      load = 1'b1; data_in = 8'h0F;
      tick();
      load = 1'b0; start = 1'b1; mode = 2'b00; shamt = 4'd5; ser_in = 1'b0;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("abort_partial", data_out, 8'h3C);
      reset = 1'b1;
      #1;
      check("abort_data", data_out, 8'h00);
      check("abort_busy", busy, 1'b0);
      tick();
      reset = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (done) done_seen++;
         tick();
      end
      check("abort_no_done", done_seen, 0);
      check("abort_idle_data", data_out, 8'h00);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
